// File: rtl/inst_loader.sv
// Boot-time program loader: accepts a framed word stream (length, payload, checksum),
// writes the payload into instruction memory and releases the CPU after a clean load.
module inst_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_run,
  output logic        load_error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;

  localparam logic [16:0] MAX_W = MAX_WORDS[16:0];

  state_t      state, state_nxt;
  logic        accept;
  logic        hdr_too_big;
  logic [15:0] sum;
  logic [15:0] remaining;
  logic [15:0] wc_q;
  logic        vld_p1;
  logic [15:0] addr_p1;
  logic [15:0] wdata_p1;
  logic        cpu_run_q;
  logic        load_error_q;

  assign accept      = in_valid & in_ready;
  assign hdr_too_big = {1'b0, in_data} > MAX_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (hdr_too_big)          state_nxt = ERROR;
          else if (in_data == '0)   state_nxt = CHECK;
          else                      state_nxt = LOAD;
        end
      end
      LOAD:  if (accept && remaining == 16'd1) state_nxt = CHECK;
      CHECK: if (accept) state_nxt = (in_data == sum) ? DONE : ERROR;
      DONE:  if (restart) state_nxt = IDLE;
      ERROR: if (restart) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is forced low while reset is held so no word is taken during reset.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && (state == IDLE || state == LOAD || state == CHECK)) in_ready = 1'b1;
  end

  // Stage p0 -> p1: accepted payload word becomes a registered memory write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum          <= '0;
      remaining    <= '0;
      wc_q         <= '0;
      vld_p1       <= 1'b0;
      addr_p1      <= BASE_ADDR;
      wdata_p1     <= '0;
      cpu_run_q    <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      vld_p1       <= 1'b0;
      cpu_run_q    <= (state_nxt == DONE);
      load_error_q <= (state_nxt == ERROR);
      case (state)
        IDLE: begin
          if (accept) begin
            sum       <= '0;
            wc_q      <= '0;
            remaining <= (hdr_too_big) ? 16'd0 : in_data;
          end
        end
        LOAD: begin
          if (accept) begin
            sum       <= sum + in_data;
            wc_q      <= wc_q + 16'd1;
            remaining <= remaining - 16'd1;
            vld_p1    <= 1'b1;
            addr_p1   <= BASE_ADDR + {wc_q[14:0], 1'b0};
            wdata_p1  <= in_data;
          end
        end
        DONE, ERROR: begin
          if (restart) begin
            sum  <= '0;
            wc_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = vld_p1;
  assign imem_addr  = addr_p1;
  assign imem_wdata = wdata_p1;
  assign cpu_run    = cpu_run_q;
  assign load_error = load_error_q;
  assign word_count = wc_q;

endmodule
